// File: rtl/sensor_frame_gen_if.sv
// Pixel-side bus of the synthetic sensor: exposure pulse, frame valid,
// data enable and D lanes of 12-bit pixel data.
interface sensor_frame_gen_if #(
   parameter int D = 4
);
   logic            exp_out;
   logic            vs_out;
   logic            en_out;
   logic [12*D-1:0] dout;

   modport master (output exp_out, vs_out, en_out, dout);
   modport slave  (input  exp_out, vs_out, en_out, dout);
endinterface

// File: rtl/sensor_frame_gen.sv
// sensor_frame_gen: synthetic sensor frame source for bring-up and
// closed-loop checks of the downstream pixel path.
// Optional macro SENSOR_FRAME_GEN_LFSR_EN: pattern 3 becomes per-lane
// 12-bit LFSR noise instead of the checkerboard.
//
// state | meaning
// IDLE  | waiting for start
// EXP   | exposure pulse high, cfg_exp_time cycles
// GAP   | quiet gap between exposure end and vs rise
// ACT   | active line, vs and en high, one beat per cycle
// HBL   | horizontal blanking, vs high, en low
// DONE  | one-cycle frame end, frame_done pulse, counter update
module sensor_frame_gen #(
   parameter int D  = 4,
   parameter int CW = 16
) (
   input  logic              px_clk,
   input  logic              px_reset_n,
   input  logic              start,
   input  logic              cfg_continuous,
   input  logic [31:0]       cfg_exp_time,
   input  logic [CW-1:0]     cfg_exp_gap,
   input  logic [CW-1:0]     cfg_width,
   input  logic [CW-1:0]     cfg_lines,
   input  logic [CW-1:0]     cfg_hblank,
   input  logic [1:0]        cfg_pattern,
   input  logic [11:0]       cfg_const,
   sensor_frame_gen_if.master pix,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       frame_cnt
);

   typedef enum logic [2:0] {IDLE, EXP, GAP, ACT, HBL, DONE} state_t;

   state_t          state_q, state_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [CW-1:0]   lrem_q, lrem_d;
   logic [CW-1:0]   x_q, x_d;
   logic [CW-1:0]   line_q, line_d;
   logic [31:0]     b_q, b_d;
   logic            sh_cont_q, sh_cont_d;
   logic [CW-1:0]   sh_gap_q, sh_gap_d;
   logic [CW-1:0]   sh_width_q, sh_width_d;
   logic [CW-1:0]   sh_lines_q, sh_lines_d;
   logic [CW-1:0]   sh_hblank_q, sh_hblank_d;
   logic [1:0]      sh_pat_q, sh_pat_d;
   logic [11:0]     sh_const_q, sh_const_d;
   logic            exp_q, exp_d, vs_q, vs_d, en_q, en_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic [12*D-1:0] dout_q, dout_d;
   logic            launch, beat;

   // Down-counter reload value for a phase whose length is max(v,1).
   function automatic logic [31:0] len_m1(input logic [CW-1:0] v);
      return (v == '0) ? 32'd0 : 32'(v) - 32'd1;
   endfunction

   // Next-state, timers, frame launch and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lrem_d      = lrem_q;
      line_d      = line_q;
      x_d         = x_q;
      b_d         = b_q;
      sh_cont_d   = sh_cont_q;
      sh_gap_d    = sh_gap_q;
      sh_width_d  = sh_width_q;
      sh_lines_d  = sh_lines_q;
      sh_hblank_d = sh_hblank_q;
      sh_pat_d    = sh_pat_q;
      sh_const_d  = sh_const_q;
      frame_cnt_d = frame_cnt_q;
      launch      = 1'b0;
      beat        = 1'b0;

      case (state_q)
         IDLE: launch = start;
         EXP: begin
            if (cnt_q == 32'd0) begin
               state_d = GAP;
               cnt_d   = len_m1(sh_gap_q);
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         GAP: begin
            if (cnt_q == 32'd0) begin
               if (sh_width_q == '0 || sh_lines_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = ACT;
                  cnt_d   = 32'(sh_width_q) - 32'd1;
                  lrem_d  = sh_lines_q - CW'(1);
               end
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         ACT: begin
            if (cnt_q == 32'd0) begin
               state_d = HBL;
               cnt_d   = len_m1(sh_hblank_q);
               line_d  = line_q + CW'(1);
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         HBL: begin
            if (cnt_q == 32'd0) begin
               if (lrem_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = ACT;
                  cnt_d   = 32'(sh_width_q) - 32'd1;
                  lrem_d  = lrem_q - CW'(1);
               end
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            // Restart needs continuous both at launch and now, so clearing
            // it mid-frame stops after the current frame.
            launch  = sh_cont_q & cfg_continuous;
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         sh_cont_d   = cfg_continuous;
         sh_gap_d    = cfg_exp_gap;
         sh_width_d  = cfg_width;
         sh_lines_d  = cfg_lines;
         sh_hblank_d = cfg_hblank;
         sh_pat_d    = cfg_pattern;
         sh_const_d  = cfg_const;
         line_d      = '0;
         b_d         = 32'd0;
         if (cfg_exp_time != 32'd0) begin
            state_d = EXP;
            cnt_d   = cfg_exp_time - 32'd1;
         end else begin
            state_d = GAP;
            cnt_d   = len_m1(cfg_exp_gap);
         end
      end

      // A beat is emitted on the cycle after state_d enters/stays in ACT.
      beat = (state_d == ACT);
      x_d  = beat ? x_q + CW'(1) : '0;
      if (beat) b_d = b_q + 32'd1;

      exp_d  = (state_d == EXP);
      vs_d   = (state_d == ACT) || (state_d == HBL);
      en_d   = beat;
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      if (state_d == DONE) frame_cnt_d = frame_cnt_q + 16'd1;
   end

`ifdef SENSOR_FRAME_GEN_LFSR_EN
   logic [D-1:0][11:0] lfsr_q, lfsr_d;
`endif

   // Pixel data for the next beat; dout holds between beats.
   always_comb begin
      dout_d = dout_q;
`ifdef SENSOR_FRAME_GEN_LFSR_EN
      lfsr_d = lfsr_q;
      if (launch) begin
         for (int k = 0; k < D; k++) lfsr_d[k] = 12'hACE ^ 12'(k);
      end
`endif
      if (beat) begin
         for (int k = 0; k < D; k++) begin
            case (sh_pat_q)
               2'd0: dout_d[12*k +: 12] = sh_const_q;
               2'd1: dout_d[12*k +: 12] = 12'(b_q * 32'(D) + 32'(k));
               2'd2: dout_d[12*k +: 12] = 12'(32'(x_q) * 32'(D) + 32'(k));
`ifdef SENSOR_FRAME_GEN_LFSR_EN
               default: dout_d[12*k +: 12] = lfsr_q[k];
`else
               default: dout_d[12*k +: 12] =
                  (x_q[0] ^ line_q[0] ^ 1'(k)) ? 12'hFFF : 12'h000;
`endif
            endcase
`ifdef SENSOR_FRAME_GEN_LFSR_EN
            lfsr_d[k] = {lfsr_q[k][10:0],
                         lfsr_q[k][11] ^ lfsr_q[k][10] ^ lfsr_q[k][9] ^ lfsr_q[k][3]};
`endif
         end
      end
   end

`ifdef SENSOR_FRAME_GEN_LFSR_EN
   // Per-lane LFSR state, reseeded at every frame launch.
   always_ff @(posedge px_clk or negedge px_reset_n) begin
      if (!px_reset_n) begin
         for (int k = 0; k < D; k++) lfsr_q[k] <= 12'hACE ^ 12'(k);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

   // State, timers, shadow config and registered outputs.
   always_ff @(posedge px_clk or negedge px_reset_n) begin
      if (!px_reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         lrem_q      <= '0;
         x_q         <= '0;
         line_q      <= '0;
         b_q         <= 32'd0;
         sh_cont_q   <= 1'b0;
         sh_gap_q    <= '0;
         sh_width_q  <= '0;
         sh_lines_q  <= '0;
         sh_hblank_q <= '0;
         sh_pat_q    <= 2'd0;
         sh_const_q  <= 12'd0;
         exp_q       <= 1'b0;
         vs_q        <= 1'b0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lrem_q      <= lrem_d;
         x_q         <= x_d;
         line_q      <= line_d;
         b_q         <= b_d;
         sh_cont_q   <= sh_cont_d;
         sh_gap_q    <= sh_gap_d;
         sh_width_q  <= sh_width_d;
         sh_lines_q  <= sh_lines_d;
         sh_hblank_q <= sh_hblank_d;
         sh_pat_q    <= sh_pat_d;
         sh_const_q  <= sh_const_d;
         exp_q       <= exp_d;
         vs_q        <= vs_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
         dout_q      <= dout_d;
      end
   end

   assign pix.exp_out = exp_q;
   assign pix.vs_out  = vs_q;
   assign pix.en_out  = en_q;
   assign pix.dout    = dout_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sensor_frame_gen.sv
// Bench for sensor_frame_gen: a frame-level model expands each launched
// frame into an expected per-cycle trace that is compared every cycle.
module tb_sensor_frame_gen;
   localparam int D  = 4;
   localparam int CW = 16;

   logic            px_clk = 1'b0;
   logic            px_reset_n = 1'b0;
   logic            start = 1'b0;
   logic            cfg_continuous = 1'b0;
   logic [31:0]     cfg_exp_time = 32'd0;
   logic [CW-1:0]   cfg_exp_gap = '0, cfg_width = '0, cfg_lines = '0, cfg_hblank = '0;
   logic [1:0]      cfg_pattern = 2'd0;
   logic [11:0]     cfg_const = 12'd0;
   logic            busy, frame_done;
   logic [15:0]     frame_cnt;

   sensor_frame_gen_if #(.D(D)) pif ();

   sensor_frame_gen #(.D(D), .CW(CW)) dut (
      .px_clk(px_clk), .px_reset_n(px_reset_n), .start(start),
      .cfg_continuous(cfg_continuous), .cfg_exp_time(cfg_exp_time),
      .cfg_exp_gap(cfg_exp_gap), .cfg_width(cfg_width), .cfg_lines(cfg_lines),
      .cfg_hblank(cfg_hblank), .cfg_pattern(cfg_pattern), .cfg_const(cfg_const),
      .pix(pif.master), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 px_clk = ~px_clk;

   typedef struct {
      logic            exp;
      logic            vs;
      logic            en;
      logic            done;
      logic [12*D-1:0] data;
   } rec_t;

   rec_t            q[$];
   logic            m_cont = 1'b0;
   logic [12*D-1:0] m_dout = '0;
   logic [15:0]     m_fcnt = 16'd0;
   int              total = 0, bad = 0;
   int              exp_cycles, vs_cycles, en_beats, done_pulses, lane0_sum;
   int              lane0_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic void push(input logic e, input logic v, input logic n,
                                input logic d, input logic [12*D-1:0] dat);
      rec_t r;
      r.exp = e; r.vs = v; r.en = n; r.done = d; r.data = dat;
      q.push_back(r);
   endfunction

   // Expand one frame from the current configuration into per-cycle records.
   function automatic void gen_frame();
      int b = 0;
      int g, h;
      logic [11:0] lf[D];
      logic [12*D-1:0] dat;
      m_cont = cfg_continuous;
      for (int k = 0; k < D; k++) lf[k] = 12'hACE ^ 12'(k);
      for (int i = 0; i < int'(cfg_exp_time); i++) push(1, 0, 0, 0, '0);
      g = (cfg_exp_gap == 0) ? 1 : int'(cfg_exp_gap);
      h = (cfg_hblank == 0) ? 1 : int'(cfg_hblank);
      for (int i = 0; i < g; i++) push(0, 0, 0, 0, '0);
      if (cfg_width != 0 && cfg_lines != 0) begin
         for (int ln = 0; ln < int'(cfg_lines); ln++) begin
            for (int x = 0; x < int'(cfg_width); x++) begin
               dat = '0;
               for (int k = 0; k < D; k++) begin
                  case (cfg_pattern)
                     2'd0: dat[12*k +: 12] = cfg_const;
                     2'd1: dat[12*k +: 12] = 12'((b * D + k) % 4096);
                     2'd2: dat[12*k +: 12] = 12'((x * D + k) % 4096);
`ifdef SENSOR_FRAME_GEN_LFSR_EN
                     default: dat[12*k +: 12] = lf[k];
`else
                     default: dat[12*k +: 12] = (((x + ln) ^ k) % 2 == 1) ? 12'hFFF : 12'h000;
`endif
                  endcase
                  lf[k] = {lf[k][10:0], lf[k][11] ^ lf[k][10] ^ lf[k][9] ^ lf[k][3]};
               end
               push(0, 1, 1, 0, dat);
               b++;
            end
            for (int i = 0; i < h; i++) push(0, 1, 0, 0, '0);
         end
      end
      push(0, 0, 0, 1, '0);
   endfunction

   // Per-cycle compare against the model plus output statistics.
   always @(negedge px_clk) begin
      rec_t r;
      logic had;
      r.exp = 0; r.vs = 0; r.en = 0; r.done = 0; r.data = '0;
      had = 1'b0;
      if (!px_reset_n) begin
         q.delete();
         m_dout = '0;
         m_fcnt = 16'd0;
      end else begin
         had = (q.size() != 0);
         if (had) r = q.pop_front();
         if (r.en) m_dout = r.data;
         if (r.done) m_fcnt = m_fcnt + 16'd1;
      end
      chk("ctl{exp,vs,en,done,busy}",
          {59'd0, pif.exp_out, pif.vs_out, pif.en_out, frame_done, busy},
          {59'd0, r.exp, r.vs, r.en, r.done, had});
      chk("dout", 64'(pif.dout), 64'(m_dout));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
      if (px_reset_n) begin
         if (pif.exp_out) exp_cycles++;
         if (pif.vs_out) vs_cycles++;
         if (frame_done) done_pulses++;
         if (pif.en_out) begin
            en_beats++;
            lane0_sum += int'(pif.dout[11:0]);
            lane0_log.push_back(int'(pif.dout[11:0]));
         end
         if (had && r.done && m_cont && cfg_continuous) gen_frame();
         else if (!had && start) gen_frame();
      end
   end

   task automatic clear_mon();
      exp_cycles = 0; vs_cycles = 0; en_beats = 0; done_pulses = 0; lane0_sum = 0;
      lane0_log.delete();
   endtask

   task automatic pulse_start();
      @(posedge px_clk); #1 start = 1'b1;
      @(posedge px_clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      repeat (2) @(posedge px_clk);
      #1;
      while ((busy || q.size() != 0) && n < budget) begin
         @(posedge px_clk); #1;
         n++;
      end
      chk("idle_wait_in_budget", 64'(n < budget), 64'd1);
   endtask

   task automatic set_cfg(input int et, input int gp, input int w, input int l,
                          input int hb, input int pat, input int cst, input logic cont);
      cfg_exp_time = 32'(et); cfg_exp_gap = CW'(gp); cfg_width = CW'(w);
      cfg_lines = CW'(l); cfg_hblank = CW'(hb); cfg_pattern = 2'(pat);
      cfg_const = 12'(cst); cfg_continuous = cont;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge px_clk);
      #1 px_reset_n = 1'b1;
      @(posedge px_clk); #1;
      chk("reset_outputs", {59'd0, pif.exp_out, pif.vs_out, pif.en_out, frame_done, busy}, 64'd0);
      chk("reset_dout", 64'(pif.dout), 64'd0);
      chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);

      // Exposure length
      clear_mon();
      set_cfg(1000, 2, 2, 1, 1, 0, 5, 1'b0);
      pulse_start();
      wait_idle(3000);
      chk("exp_cycles", 64'(exp_cycles), 64'd1000);
      chk("exp_done_pulses", 64'(done_pulses), 64'd1);
      chk("exp_frame_cnt", 64'(frame_cnt), 64'd1);

      // Geometry with constant pattern
      clear_mon();
      set_cfg(3, 0, 10, 4, 3, 0, 100, 1'b0);
      pulse_start();
      wait_idle(500);
      chk("geo_en_beats", 64'(en_beats), 64'd40);
      chk("geo_lane0_sum", 64'(lane0_sum), 64'd4000);
      chk("geo_vs_cycles", 64'(vs_cycles), 64'd52);
      chk("geo_frame_cnt", 64'(frame_cnt), 64'd2);

      // Frame ramp
      clear_mon();
      set_cfg(1, 1, 8, 2, 1, 1, 0, 1'b0);
      pulse_start();
      wait_idle(500);
      chk("ramp_beats", 64'(lane0_log.size()), 64'd16);
      for (int i = 0; i < lane0_log.size(); i++) chk("ramp_lane0", 64'(lane0_log[i]), 64'(4 * i));

      // Line gradient
      clear_mon();
      set_cfg(1, 1, 8, 2, 1, 2, 0, 1'b0);
      pulse_start();
      wait_idle(500);
      chk("grad_beats", 64'(lane0_log.size()), 64'd16);
      if (lane0_log.size() == 16) begin
         chk("grad_line1_last", 64'(lane0_log[7]), 64'd28);
         chk("grad_line2_first", 64'(lane0_log[8]), 64'd0);
      end

      // Pattern 3, compared against the model only
      clear_mon();
      set_cfg(2, 1, 4, 3, 2, 3, 0, 1'b0);
      pulse_start();
      wait_idle(500);
      chk("pat3_beats", 64'(en_beats), 64'd12);

      // Degenerate frame
      clear_mon();
      set_cfg(0, 0, 5, 0, 0, 0, 7, 1'b0);
      pulse_start();
      wait_idle(100);
      chk("degen_exp_cycles", 64'(exp_cycles), 64'd0);
      chk("degen_vs_cycles", 64'(vs_cycles), 64'd0);
      chk("degen_done", 64'(done_pulses), 64'd1);
      chk("degen_busy_low", 64'(busy), 64'd0);
      chk("degen_frame_cnt", 64'(frame_cnt), 64'd6);

      // Continuous run with mid-frame reconfiguration
      clear_mon();
      set_cfg(5, 1, 10, 2, 1, 0, 1, 1'b1);
      pulse_start();
      repeat (8) @(posedge px_clk);
      #1 cfg_width = CW'(20);
      pulse_start();
      n = 0;
      while (done_pulses < 2 && n < 500) begin
         @(posedge px_clk); #1;
         n++;
      end
      chk("cont_second_frame_in_budget", 64'(n < 500), 64'd1);
      repeat (5) @(posedge px_clk);
      #1 cfg_continuous = 1'b0;
      wait_idle(500);
      repeat (20) @(posedge px_clk);
      #1;
      chk("cont_frames", 64'(done_pulses), 64'd3);
      chk("cont_en_beats", 64'(en_beats), 64'd100);
      chk("cont_busy_low", 64'(busy), 64'd0);
      chk("cont_frame_cnt", 64'(frame_cnt), 64'd9);

      // Reset in the middle of a frame
      clear_mon();
      set_cfg(2, 1, 10, 4, 2, 1, 0, 1'b0);
      pulse_start();
      n = 0;
      while (!pif.en_out && n < 100) begin
         @(posedge px_clk); #1;
         n++;
      end
      chk("rst_reach_act", 64'(n < 100), 64'd1);
      #2 px_reset_n = 1'b0;
      #1;
      chk("rst_ctl_zero", {59'd0, pif.exp_out, pif.vs_out, pif.en_out, frame_done, busy}, 64'd0);
      chk("rst_dout_zero", 64'(pif.dout), 64'd0);
      chk("rst_frame_cnt_zero", 64'(frame_cnt), 64'd0);
      repeat (2) @(posedge px_clk);
      #1 px_reset_n = 1'b1;
      repeat (2) @(posedge px_clk);
      #1;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      clear_mon();
      pulse_start();
      wait_idle(500);
      chk("post_rst_en_beats", 64'(en_beats), 64'd40);
      chk("post_rst_frame_cnt_one", 64'(frame_cnt), 64'd1);

      repeat (3) @(posedge px_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
